// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the fetch stage and downstream pipeline registers.
package fetch_stage_pkg;

    localparam int          PC_W     = 16;
    localparam logic [15:0] NOP_INST = 16'h0800;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    // Sequential PC increment; wraps modulo 2^16.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + 16'd2;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: instruction, PC+2 and valid, with hold and bubble controls.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] NOP = fetch_stage_pkg::NOP_INST
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold_i,
    input  logic            bubble_i,
    input  logic [PC_W-1:0] inst_i,
    input  logic [PC_W-1:0] pc_plus2_i,
    input  logic            valid_i,
    output logic [PC_W-1:0] inst_o,
    output logic [PC_W-1:0] pc_plus2_o,
    output logic            valid_o
);

    logic [PC_W-1:0] inst_q, inst_d;
    logic [PC_W-1:0] pc_plus2_q, pc_plus2_d;
    logic            valid_q, valid_d;

    // Bubble overrides hold so a squash always wins over a stall.
    always_comb begin
        inst_d     = inst_q;
        pc_plus2_d = pc_plus2_q;
        valid_d    = valid_q;
        if (bubble_i) begin
            inst_d     = NOP;
            pc_plus2_d = 16'h0000;
            valid_d    = 1'b0;
        end else if (hold_i) begin
            inst_d     = inst_q;
            pc_plus2_d = pc_plus2_q;
            valid_d    = valid_q;
        end else begin
            inst_d     = inst_i;
            pc_plus2_d = pc_plus2_i;
            valid_d    = valid_i;
        end
    end

    // Register update with asynchronous reset to a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_q     <= NOP;
            pc_plus2_q <= 16'h0000;
            valid_q    <= 1'b0;
        end else begin
            inst_q     <= inst_d;
            pc_plus2_q <= pc_plus2_d;
            valid_q    <= valid_d;
        end
    end

    assign inst_o     = inst_q;
    assign pc_plus2_o = pc_plus2_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, run/halt FSM and IF/ID register.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = fetch_stage_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] inst_out,
    output logic [15:0] pc_plus2_out,
    output logic        valid_out,
    output logic        halted
);

    import fetch_stage_pkg::*;

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_plus2_s;
    logic            hold_s;
    logic            bubble_s;

    assign pc_plus2_s = pc_inc(pc_q);

    // Next-state, next-PC and IF/ID control; priority redirect > halted > stall > halt_req.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        hold_s   = 1'b0;
        bubble_s = 1'b0;
        if (redirect) begin
            pc_d     = redirect_pc & 16'hFFFE;
            bubble_s = 1'b1;
            state_d  = RUN;
        end else begin
            case (state_q)
                HALTED: begin
                    bubble_s = 1'b1;
                end
                RUN: begin
                    if (stall) begin
                        hold_s = 1'b1;
                    end else if (halt_req) begin
                        bubble_s = 1'b1;
                        state_d  = HALTED;
                    end else begin
                        pc_d = pc_plus2_s;
                    end
                end
                default: begin
                    bubble_s = 1'b1;
                    state_d  = RUN;
                end
            endcase
        end
    end

    // PC and FSM state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            state_q <= RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    if_id_reg #(
        .NOP (NOP_INST)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .hold_i     (hold_s),
        .bubble_i   (bubble_s),
        .inst_i     (imem_data),
        .pc_plus2_i (pc_plus2_s),
        .valid_i    (1'b1),
        .inst_o     (inst_out),
        .pc_plus2_o (pc_plus2_out),
        .valid_o    (valid_out)
    );

    assign imem_addr = pc_q;
    assign halted    = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; imem returns 16'h4000 + address.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halt_req = 1'b0;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] inst_out;
    logic [15:0] pc_plus2_out;
    logic        valid_out;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    fetch_stage #(
        .RESET_PC (16'h0000),
        .NOP_INST (16'h0800)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .halt_req     (halt_req),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .inst_out     (inst_out),
        .pc_plus2_out (pc_plus2_out),
        .valid_out    (valid_out),
        .halted       (halted)
    );

    assign imem_data = 16'h4000 + imem_addr;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [15:0] addr, input logic [15:0] inst,
                             input logic [15:0] pp2, input logic valid, input logic hlt);
        check({tag, ".addr"}, imem_addr, addr);
        check({tag, ".inst"}, inst_out, inst);
        check({tag, ".pc2"}, pc_plus2_out, pp2);
        check({tag, ".valid"}, {15'd0, valid_out}, {15'd0, valid});
        check({tag, ".halted"}, {15'd0, halted}, {15'd0, hlt});
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        check_all("reset", 16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;

        // straight-line fetch
        step(); check_all("fetch0", 16'h0002, 16'h4000, 16'h0002, 1'b1, 1'b0);
        step(); check_all("fetch1", 16'h0004, 16'h4002, 16'h0004, 1'b1, 1'b0);
        step(); check_all("fetch2", 16'h0006, 16'h4004, 16'h0006, 1'b1, 1'b0);

        // two-cycle stall at PC 0006
        stall = 1'b1;
        step(); check_all("stall0", 16'h0006, 16'h4004, 16'h0006, 1'b1, 1'b0);
        step(); check_all("stall1", 16'h0006, 16'h4004, 16'h0006, 1'b1, 1'b0);
        stall = 1'b0;
        step(); check_all("unstall", 16'h0008, 16'h4006, 16'h0008, 1'b1, 1'b0);

        // redirect beats stall and halt, odd target bit dropped
        redirect = 1'b1; redirect_pc = 16'h0021; stall = 1'b1; halt_req = 1'b1;
        step(); check_all("redir", 16'h0020, 16'h0800, 16'h0000, 1'b0, 1'b0);
        redirect = 1'b0; stall = 1'b0; halt_req = 1'b0;
        step(); check_all("redir_tgt", 16'h0022, 16'h4020, 16'h0022, 1'b1, 1'b0);

        // move to PC 0010, then halt_req under stall is deferred
        redirect = 1'b1; redirect_pc = 16'h0010;
        step(); check_all("to_0010", 16'h0010, 16'h0800, 16'h0000, 1'b0, 1'b0);
        redirect = 1'b0; stall = 1'b1; halt_req = 1'b1;
        step(); check_all("halt_stalled", 16'h0010, 16'h0800, 16'h0000, 1'b0, 1'b0);
        stall = 1'b0;
        step(); check_all("halt", 16'h0010, 16'h0800, 16'h0000, 1'b0, 1'b1);
        halt_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            stall = i[0];
            halt_req = i[1];
            step(); check_all("halted_hold", 16'h0010, 16'h0800, 16'h0000, 1'b0, 1'b1);
        end
        stall = 1'b0; halt_req = 1'b0;

        // resume from halt via redirect
        redirect = 1'b1; redirect_pc = 16'h0100;
        step(); check_all("resume", 16'h0100, 16'h0800, 16'h0000, 1'b0, 1'b0);
        redirect = 1'b0;
        step(); check_all("resume_tgt", 16'h0102, 16'h4100, 16'h0102, 1'b1, 1'b0);

        // wrap-around at FFFE
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        step(); check_all("to_fffe", 16'hFFFE, 16'h0800, 16'h0000, 1'b0, 1'b0);
        redirect = 1'b0;
        step(); check_all("wrap0", 16'h0000, 16'h3FFE, 16'h0000, 1'b1, 1'b0);
        step(); check_all("wrap1", 16'h0002, 16'h4000, 16'h0002, 1'b1, 1'b0);

        // asynchronous reset at PC 0040
        redirect = 1'b1; redirect_pc = 16'h003E;
        step();
        redirect = 1'b0;
        step(); check_all("pre_rst", 16'h0040, 16'h403E, 16'h0040, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 check_all("async_rst", 16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        step(); check_all("post_rst", 16'h0002, 16'h4000, 16'h0002, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 16-bit five-stage pipeline, directly upstream of decode. It owns the program counter, drives the instruction-memory address, and holds the IF/ID pipeline register that decode consumes. It handles stall, branch/jump redirect with squash, and halt.

## Interface

**Parameters**
- `RESET_PC`, default `16'h0000`: PC value loaded on reset.
- `NOP_INST`, default `16'h0800`: NOP encoding (opcode `00001`) used for bubbles.

**Ports**
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst`, in, 1: reset. **Asynchronous, active-high.**
- `stall`, in, 1: hazard stall from decode. Holds PC and IF/ID.
- `redirect`, in, 1: taken branch or jump resolved downstream.
- `redirect_pc`, in, 16: redirect target. Bit 0 is ignored.
- `halt_req`, in, 1: the instruction in IF/ID decodes as HALT (the inverse of decode's `Halt_n`).
- `imem_addr`, out, 16: instruction-memory address, equal to the current PC (combinational).
- `imem_data`, in, 16: instruction word, combinational read of `imem_addr`.
- `inst_out`, out, 16: IF/ID instruction register.
- `pc_plus2_out`, out, 16: IF/ID register holding PC+2 of `inst_out`.
- `valid_out`, out, 1: IF/ID holds a real fetched instruction (0 means bubble).
- `halted`, out, 1: fetch has stopped after a HALT.

## Operation

- **State machine:** two states, `RUN` and `HALTED`. Reset state is `RUN`.
- **Per-edge priority** (highest first): rst > redirect > stall > halt_req > normal fetch.
- **redirect** (from any state):
  - PC <= {redirect_pc[15:1], 1'b0}
  - IF/ID <= NOP_INST, valid 0, pc_plus2 0
  - state <= RUN
  - The wrong-path instruction currently being fetched, and any `halt_req` in the same cycle, are discarded.
- **stall** (no redirect): PC, IF/ID and state hold unchanged. A `halt_req` during a stall is not taken; it is honoured on the first non-stalled edge.
- **halt_req in RUN:**
  - PC holds
  - IF/ID <= NOP, valid 0
  - state <= HALTED
  - The HALT instruction itself passes on to decode's downstream register on the same edge.
- **HALTED:**
  - PC holds
  - IF/ID held at NOP, valid 0
  - `halted` = 1
  - `halt_req` and `stall` are ignored. Only `redirect` or `rst` leaves this state.
- **Normal fetch:**
  - PC <= PC + 2
  - inst_out <= imem_data
  - pc_plus2_out <= PC + 2
  - valid_out <= 1
- **Arithmetic:** PC+2 is a 16-bit add that wraps modulo 2^16, so `16'hFFFE` + 2 = `16'h0000`. PC[0] is always 0.
- **Reset values:**
  - PC = RESET_PC
  - inst_out = NOP_INST
  - pc_plus2_out = 0
  - valid_out = 0
  - halted = 0
  - state = RUN
- `imem_addr` follows PC immediately on reset assertion, without waiting for a clock edge.

## Timing

- Fetch latency is one cycle: the word at PC appears on `inst_out` on the edge that advances PC.
- After a redirect, the target instruction appears on `inst_out` two edges later. Exactly one bubble is inserted by fetch.
- `halted` rises on the edge that samples `halt_req` (with no stall and no redirect). It falls on the edge that samples `redirect`, or asynchronously on `rst`.
- Reset asserted mid-operation clears all state immediately. On the first edge after deassertion the block fetches from RESET_PC.
- `imem_addr` is combinational from the PC register only. There is no input-to-output combinational path.

## Structure

- **Shared package:** `NOP_INST`, the state enum `{RUN, HALTED}`, and the 16-bit PC width constant. Decode and the later pipeline registers use the same NOP constant.
- **One sub-module, `if_id_reg`:** a 16+16+1-bit register with async reset to NOP/0/0, a hold input (stall) and a bubble input (redirect/halt), with bubble taking priority over hold.
- The PC register, next-PC mux and state machine live in `fetch_stage`.

## Test plan

- **Reset and straight-line fetch:**
  - Stimulus: RESET_PC = 0, imem returns `16'h4000 + addr`, run 3 edges.
  - Required: inst_out = `4000`, `4002`, `4004` on successive edges; pc_plus2_out = 2, 4, 6; valid 1.
- **Stall:**
  - Stimulus: stall held for 2 cycles at PC = `16'h0006`.
  - Required: PC and IF/ID unchanged throughout. On release, inst_out = `4006` on the next edge.
- **Redirect with stall and halt in the same cycle:**
  - Stimulus: redirect = 1, redirect_pc = `16'h0021`, stall = 1, halt_req = 1.
  - Required: PC = `16'h0020`, inst_out = `0800`, valid 0, halted 0. The next edge gives inst_out = `4020`.
- **Halt then resume:**
  - Stimulus: halt_req pulsed at PC = `16'h0010`.
  - Required: halted = 1, PC stays `0010`, IF/ID = NOP for 5 cycles even with stall toggling.
  - Then: redirect to `16'h0100` gives halted = 0 and inst_out = `4100` two edges later.
- **Wrap-around:**
  - Stimulus: redirect to `16'hFFFE`.
  - Required: following fetches give pc_plus2_out = `0000` and imem_addr = `0000`.
- **Asynchronous reset mid-run:**
  - Stimulus: rst asserted between edges at PC = `16'h0040`.
  - Required: imem_addr = RESET_PC and valid_out = 0 immediately, before the next clock edge.
